noc_input_buffer: RTL
=====================

Name: noc_input_buffer

Overview:
Receiver end of the credit-based flit link; one instance per router input port, including the local inject port fed by the processor element.
- Accepts 20-bit flits qualified by a valid strobe and stores them in a FIFO.
- Presents the head flit with an XY-routed output-port request to the switch.
- Returns one credit pulse to the upstream transmitter for every flit that leaves the FIFO.

Parameters:
DEPTH, 4, FIFO entries; also the upstream initial credit count; power of two, at least 2.
FLIT_W, 20, flit width; bits [19:16] are the destination position, bits [15:0] are payload.

Ports:
clk  input  1  sole clock; all state changes on the rising edge.
RST  input  1  asynchronous, active-low reset.
position  input  4  this node's coordinates; [3:2] = y (row), [1:0] = x (column).
in  input  FLIT_W  incoming flit.
vi  input  1  in is valid this cycle.
co  output  1  credit return to the upstream transmitter; one-cycle pulse.
out_flit  output  FLIT_W  head-of-FIFO flit.
out_valid  output  1  FIFO not empty.
out_req  output  5  one-hot output request for the head flit: [0]=N, [1]=E, [2]=S, [3]=W, [4]=Local; all zero when out_valid=0.
deq  input  1  switch grant; pops the head flit this cycle.

Behaviour:
- Reset (RST low, asynchronous):
  - count=0, read and write pointers=0.
  - co=0, out_valid=0, out_req=0.
  - out_flit is don't-care; RTL drives it to 0.
  - Reset mid-operation discards all stored flits. The upstream transmitter re-initialises to DEPTH credits on the same reset.
- Enqueue:
  - Occurs when vi=1 and count<DEPTH.
  - Flit written at wptr; wptr increments modulo DEPTH.
  - Visible at out_flit the next cycle if the FIFO was empty. No bypass, so minimum in-to-out latency is 1 cycle.
- Dequeue:
  - Occurs when deq=1 and out_valid=1; rptr increments modulo DEPTH.
  - deq while empty is ignored: no pointer change, no credit.
- Simultaneous enqueue and dequeue (non-full): count unchanged and both pointers advance.
- vi=1 while count==DEPTH is a protocol violation.
  - The flit is dropped, even if deq=1 in the same cycle.
  - The same-cycle dequeue still completes and still returns its credit.
- Credit: co is registered and equals 1 exactly in the cycle after each dequeue. Back-to-back dequeues give back-to-back co pulses. Reset never generates a credit.
- out_flit and out_valid are driven combinationally from FIFO storage and count.
- Route, combinational from out_flit[19:16] = {dy, dx} versus position = {cy, cx}:
  - dx>cx: E
  - dx<cx: W
  - dx==cx and dy>cy: S
  - dx==cx and dy<cy: N
  - otherwise: Local
- Pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.
- Unsigned 2-bit compares; no arithmetic overflow is possible.

Optional Feature:
NOC_INBUF_ERR_EN
- Defined: adds output port ovf_err (1 bit).
  - Sticky flag, set the cycle after any vi=1 while full.
  - Cleared only by RST.
  - Adds output port drop_cnt (8 bits), a saturating count of dropped flits; both reset to 0.
- Undefined: neither port exists. Overflow flits are silently dropped and all other behaviour is identical.

Decomposition:
- Package noc_pkg:
  - FLIT_W.
  - DEST_HI=19, DEST_LO=16.
  - Port index constants: PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4.
  - Flit typedef.
  - 5-bit request typedef.
- Sub-module xy_route_calc: purely combinational (position, dest, valid) -> 5-bit one-hot request. Shared with other router ports and unit-tested separately.
- FIFO storage and credit logic stay in noc_input_buffer.

Test Plan:
1. Reset then idle, position=4'b0101:
   - out_valid=0, out_req=0, co=0 throughout.
   - deq=1 pulses produce no co.
2. Single flit in=20'h9_1234 (dest y=2, x=1) at position 4'b0101, deq=1 on first valid cycle:
   - out_valid rises 1 cycle after vi.
   - out_req=5'b00100 (S).
   - co=1 exactly one cycle after deq.
3. Routing sweep at position 4'b0101: dest 4'h7->E (00010), 4'h4->W (01000), 4'h1->N (00001), 4'h5->Local (10000).
4. Fill DEPTH=4 flits A,B,C,D with deq=0, then drain with deq held 1:
   - Output order A,B,C,D.
   - Four consecutive co pulses.
   - out_valid falls after D.
5. Full FIFO, vi=1 with flit E and deq=1 in the same cycle:
   - E dropped.
   - A dequeued, co pulses.
   - Subsequent output B,C,D only.
   - With NOC_INBUF_ERR_EN: ovf_err=1 and drop_cnt=1 next cycle.
6. Assert RST low mid-drain with 2 flits stored:
   - Outputs clear immediately (asynchronously).
   - No credit is issued.
   - After release, a new flit 20'h5_00AA routes Local and dequeues normally.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit/request types and port index constants for the router input side.
package noc_pkg;
    localparam int FLIT_W  = 20;
    localparam int DEST_HI = 19;
    localparam int DEST_LO = 16;
    localparam int PORT_N  = 0;
    localparam int PORT_E  = 1;
    localparam int PORT_S  = 2;
    localparam int PORT_W  = 3;
    localparam int PORT_L  = 4;
    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [4:0]        req_t;
endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational XY (x first) routing of a destination to a one-hot output request.
module xy_route_calc
    import noc_pkg::*;
(
    input  logic [3:0] position,
    input  logic [3:0] dest,
    input  logic       valid,
    output req_t       req
);
    logic [1:0] cx, cy, dx, dy;
    assign {cy, cx} = position;
    assign {dy, dx} = dest;
    assign req = !valid  ? req_t'(0) :
                 dx > cx ? req_t'(1) << PORT_E :
                 dx < cx ? req_t'(1) << PORT_W :
                 dy > cy ? req_t'(1) << PORT_S :
                 dy < cy ? req_t'(1) << PORT_N :
                           req_t'(1) << PORT_L;
endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: credit-based receive FIFO with XY route request for the head flit.
// Optional NOC_INBUF_ERR_EN adds sticky overflow flag ovf_err and saturating drop_cnt.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] position,
    input  flit_t      in,
    input  logic       vi,
    output logic       co,
    output flit_t      out_flit,
    output logic       out_valid,
    output req_t       out_req,
`ifdef NOC_INBUF_ERR_EN
    output logic       ovf_err,
    output logic [7:0] drop_cnt,
`endif
    input  logic       deq
);
    localparam int AW = $clog2(DEPTH);

    flit_t         mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          co_q, full, enq, pop;

    assign full      = count_q == (AW+1)'(DEPTH);
    assign enq       = vi && !full;
    assign pop       = deq && out_valid;
    assign count_d   = count_q + (AW+1)'(enq) - (AW+1)'(pop);
    assign out_valid = count_q != '0;
    assign out_flit  = out_valid ? mem_q[rptr_q] : '0;
    assign co        = co_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            co_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_q + AW'(enq);
            rptr_q  <= rptr_q + AW'(pop);
            count_q <= count_d;
            co_q    <= pop;
        end
    end

    // storage needs no reset: out_flit is masked while empty
    always_ff @(posedge clk) begin
        if (enq) mem_q[wptr_q] <= in;
    end

    xy_route_calc u_route (
        .position (position),
        .dest     (out_flit[DEST_HI:DEST_LO]),
        .valid    (out_valid),
        .req      (out_req)
    );

`ifdef NOC_INBUF_ERR_EN
    logic       ovf_q;
    logic [7:0] drop_q;
    assign ovf_err  = ovf_q;
    assign drop_cnt = drop_q;
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (vi && full) begin
            ovf_q  <= 1'b1;
            drop_q <= drop_q + 8'(drop_q != 8'hFF);
        end
    end
`endif
endmodule
